// File: rtl/console_pkg.sv
// Shared definitions for the text console: default screen geometry,
// control-code byte values and the write-side state encoding.
// The console driver (VGA scan side) pulls DEF_COLS/DEF_ROWS from here
// so both sides agree on the character memory layout.
package console_pkg;

  // Default screen geometry (characters).
  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  // Control codes interpreted by the writer.
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_CLEAR_LINE = 2'd2,
    ST_CLEAR_ALL  = 2'd3
  } state_t;

  // Printable ASCII range: space through tilde.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_writer.sv
// console_writer: write-side controller for the console character memory.
// Accepts bytes over a valid/ready handshake, renders printable characters,
// handles BS/LF/CR/FF, and sequences one-write-per-cycle fills for line and
// screen clears. Every output is a register.
//
// Ports:
//   clk       system clock, also the memory write-port clock
//   rst       synchronous active-high reset (restarts a full screen clear)
//   in_data   byte to render, sampled only when accepted
//   in_valid  in_data is valid
//   in_ready  high while idle; a byte is accepted on in_valid && in_ready
//   mem_addr  write address (16-bit, truncating)
//   mem_data  write data
//   mem_we    write strobe, one write per cycle while high
//   cursor_x  current column
//   cursor_y  current row
//   busy      high whenever the controller is not idle
module console_writer
  import console_pkg::*;
#(
  parameter int          COLS = DEF_COLS,
  parameter int          ROWS = DEF_ROWS,
  parameter logic [15:0] BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  output logic [6:0]  cursor_x,
  output logic [5:0]  cursor_y,
  output logic        busy
);

  localparam logic [15:0] COLS_W   = 16'(COLS);
  localparam logic [15:0] FILL_ALL = 16'(ROWS * COLS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

  state_t      state, state_nxt;
  logic [6:0]  x_nxt;
  logic [5:0]  y_nxt;
  logic [15:0] linebase, lb_nxt;
  // Number of fill writes already issued in the current clear.
  logic [15:0] fill_cnt, fill_nxt;
  // A printable at the last column must follow its write with a line clear.
  logic        wrap_pend, wrap_nxt;

  logic        we_nxt;
  logic [15:0] addr_nxt;
  logic [7:0]  data_nxt;

  logic        accept;
  logic        at_last_row;
  logic [5:0]  y_adv;
  logic [15:0] lb_adv;
  logic [15:0] cur_addr;

  assign accept      = in_valid && in_ready;
  assign at_last_row = (cursor_y == LAST_ROW);
  // Row advance without scrolling: wrap to row 0 and reload the base.
  assign y_adv       = at_last_row ? 6'd0 : cursor_y + 6'd1;
  assign lb_adv      = at_last_row ? BASE : linebase + COLS_W;
  assign cur_addr    = linebase + {9'd0, cursor_x};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR_ALL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and cursor/fill bookkeeping
  always_comb begin
    state_nxt = state;
    x_nxt     = cursor_x;
    y_nxt     = cursor_y;
    lb_nxt    = linebase;
    fill_nxt  = fill_cnt;
    wrap_nxt  = wrap_pend;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(in_data)) begin
            state_nxt = ST_WRITE;
            if (cursor_x == LAST_COL) begin
              x_nxt    = 7'd0;
              y_nxt    = y_adv;
              lb_nxt   = lb_adv;
              wrap_nxt = 1'b1;
            end else begin
              x_nxt    = cursor_x + 7'd1;
              wrap_nxt = 1'b0;
            end
          end else begin
            case (in_data)
              CH_LF: begin
                // First blanking write goes out with the accept itself.
                x_nxt     = 7'd0;
                y_nxt     = y_adv;
                lb_nxt    = lb_adv;
                fill_nxt  = 16'd1;
                state_nxt = ST_CLEAR_LINE;
              end
              CH_CR: begin
                x_nxt = 7'd0;
              end
              CH_BS: begin
                if (cursor_x != 7'd0) begin
                  x_nxt     = cursor_x - 7'd1;
                  wrap_nxt  = 1'b0;
                  state_nxt = ST_WRITE;
                end
              end
              CH_FF: begin
                x_nxt     = 7'd0;
                y_nxt     = 6'd0;
                lb_nxt    = BASE;
                fill_nxt  = 16'd1;
                state_nxt = ST_CLEAR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      ST_WRITE: begin
        if (wrap_pend) begin
          fill_nxt  = 16'd1;
          wrap_nxt  = 1'b0;
          state_nxt = ST_CLEAR_LINE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR_LINE: begin
        if (fill_cnt < COLS_W) fill_nxt = fill_cnt + 16'd1;
        else                   state_nxt = ST_IDLE;
      end
      ST_CLEAR_ALL: begin
        if (fill_cnt < FILL_ALL) fill_nxt = fill_cnt + 16'd1;
        else                     state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write-port values for the next cycle
  always_comb begin
    we_nxt   = 1'b0;
    addr_nxt = mem_addr;
    data_nxt = mem_data;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(in_data)) begin
            we_nxt   = 1'b1;
            addr_nxt = cur_addr;
            data_nxt = in_data;
          end else begin
            case (in_data)
              CH_LF: begin
                we_nxt   = 1'b1;
                addr_nxt = lb_adv;
                data_nxt = CH_SPACE;
              end
              CH_BS: begin
                if (cursor_x != 7'd0) begin
                  we_nxt   = 1'b1;
                  addr_nxt = cur_addr - 16'd1;
                  data_nxt = CH_SPACE;
                end
              end
              CH_FF: begin
                we_nxt   = 1'b1;
                addr_nxt = BASE;
                data_nxt = CH_SPACE;
              end
              default: ;
            endcase
          end
        end
      end
      ST_WRITE: begin
        // linebase already points at the new row here.
        if (wrap_pend) begin
          we_nxt   = 1'b1;
          addr_nxt = linebase;
          data_nxt = CH_SPACE;
        end
      end
      ST_CLEAR_LINE: begin
        if (fill_cnt < COLS_W) begin
          we_nxt   = 1'b1;
          addr_nxt = linebase + fill_cnt;
          data_nxt = CH_SPACE;
        end
      end
      ST_CLEAR_ALL: begin
        if (fill_cnt < FILL_ALL) begin
          we_nxt   = 1'b1;
          addr_nxt = BASE + fill_cnt;
          data_nxt = CH_SPACE;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk) begin
    if (rst) begin
      cursor_x  <= 7'd0;
      cursor_y  <= 6'd0;
      linebase  <= BASE;
      fill_cnt  <= 16'd0;
      wrap_pend <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_data  <= CH_SPACE;
    end else begin
      cursor_x  <= x_nxt;
      cursor_y  <= y_nxt;
      linebase  <= lb_nxt;
      fill_cnt  <= fill_nxt;
      wrap_pend <= wrap_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_data  <= data_nxt;
    end
  end

endmodule
